// File: rtl/snake_ring_engine.sv
// snake_ring_engine
// Snake game core. The body is a circular list of cell coordinates held in a
// single-clock inferred RAM (head_ptr/tail_ptr), mirrored by a GRID_W*GRID_H
// occupancy bitmap that a renderer can read directly.
//
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   step_valid/ready  move handshake; ready only while idle
//   dir               00 x+1, 01 x-1, 10 y+1, 11 y-1
//   food_x/food_y     food cell, sampled when a step is accepted
//   restart           sync re-initialise from any state
//   step_done, ate    1-cycle pulses at the end of every accepted step
//   game_over, win    sticky levels until restart/reset
//   length            body length 1..DEPTH
//   head_x/head_y     current head cell
//   occ_map           occupancy bitmap, bit y*GRID_W+x
//
// state | meaning
// INIT  | write start cell into RAM[0]
// IDLE  | step_ready high, wait for a step
// RD    | tail address presented to RAM
// CHK   | next cell, grow, wall/collision/win decided
// WR    | commit head, RAM entry, occupancy, pointers, length
// DONE  | step_done/ate pulse
// OVER  | frozen until restart
module snake_ring_engine #(
  parameter int GRID_W  = 16,
  parameter int GRID_H  = 16,
  parameter int DEPTH   = 256,
  parameter int START_X = 8,
  parameter int START_Y = 8,
  parameter int WRAP    = 0,
  localparam int XW     = $clog2(GRID_W),
  localparam int YW     = $clog2(GRID_H),
  localparam int AW     = $clog2(DEPTH),
  localparam int NCELL  = GRID_W * GRID_H
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_valid,
  output logic             step_ready,
  input  logic [1:0]       dir,
  input  logic [XW-1:0]    food_x,
  input  logic [YW-1:0]    food_y,
  input  logic             restart,
  output logic             step_done,
  output logic             ate,
  output logic             game_over,
  output logic             win,
  output logic [AW:0]      length,
  output logic [XW-1:0]    head_x,
  output logic [YW-1:0]    head_y,
  output logic [NCELL-1:0] occ_map
);

  localparam int CW        = XW + YW;
  localparam int IW        = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam int START_IDX = START_Y * GRID_W + START_X;
  localparam logic [NCELL-1:0] OCC_START = {{(NCELL-1){1'b0}}, 1'b1} << START_IDX;
  localparam logic [XW-1:0] SX       = XW'(START_X);
  localparam logic [YW-1:0] SY       = YW'(START_Y);
  localparam logic [XW-1:0] X_MAX    = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX    = YW'(GRID_H - 1);
  localparam logic [AW:0]   LEN_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LEN_FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_CHK, S_WR, S_DONE, S_OVER} state_t;

  state_t        state;
  logic [AW-1:0] head_ptr, tail_ptr;
  logic [1:0]    dir_q, last_dir;
  logic [XW-1:0] food_xq, nxt_x;
  logic [YW-1:0] food_yq, nxt_y;
  logic [IW-1:0] nxt_idx, tail_idx;
  logic          grow_q;

  function automatic logic [IW-1:0] cell_idx(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return IW'(y) * IW'(GRID_W) + IW'(x);
  endfunction

  // Body list RAM: one write port, one registered read port on tail_ptr.
  logic [CW-1:0] mem [DEPTH];
  logic [CW-1:0] rd_data;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [CW-1:0] mem_wdata;

  assign mem_we    = !restart && ((state == S_INIT) || (state == S_WR));
  assign mem_waddr = (state == S_WR) ? head_ptr + AW'(1) : '0;
  assign mem_wdata = (state == S_WR) ? {nxt_y, nxt_x} : {SY, SX};

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    rd_data <= mem[tail_ptr];
  end

  // Next-cell computation, valid in CHK (head and dir_q are stable there).
  logic [XW-1:0] cx, tail_x;
  logic [YW-1:0] cy, tail_y;
  logic          wall;

  always_comb begin
    cx   = head_x;
    cy   = head_y;
    wall = 1'b0;
    case (dir_q)
      2'b00: if (head_x == X_MAX) begin
               if (WRAP != 0) cx = '0; else wall = 1'b1;
             end else cx = head_x + XW'(1);
      2'b01: if (head_x == '0) begin
               if (WRAP != 0) cx = X_MAX; else wall = 1'b1;
             end else cx = head_x - XW'(1);
      2'b10: if (head_y == Y_MAX) begin
               if (WRAP != 0) cy = '0; else wall = 1'b1;
             end else cy = head_y + YW'(1);
      default: if (head_y == '0) begin
               if (WRAP != 0) cy = Y_MAX; else wall = 1'b1;
             end else cy = head_y - YW'(1);
    endcase
  end

  assign tail_x = rd_data[XW-1:0];
  assign tail_y = rd_data[CW-1:XW];

  logic [IW-1:0] c_idx;
  logic          c_grow, c_hit, c_lose, c_win;
  logic [1:0]    dir_eff;

  assign c_idx  = cell_idx(cx, cy);
  assign c_grow = (cx == food_xq) && (cy == food_yq);
  // Moving onto the tail is legal unless the tail stays put because we grow.
  assign c_hit  = occ_map[c_idx] && !((cx == tail_x) && (cy == tail_y) && !c_grow);
  assign c_lose = wall || c_hit;
  assign c_win  = !c_lose && c_grow && (length == LEN_FULL);

  // A reversal into the neck is replaced by the previous direction.
  assign dir_eff = ((length != LEN_ONE) && (dir == {last_dir[1], ~last_dir[0]})) ? last_dir : dir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_INIT;
      step_ready <= 1'b0;
      step_done  <= 1'b0;
      ate        <= 1'b0;
      game_over  <= 1'b0;
      win        <= 1'b0;
      length     <= LEN_ONE;
      head_x     <= SX;
      head_y     <= SY;
      occ_map    <= OCC_START;
      head_ptr   <= '0;
      tail_ptr   <= '0;
      dir_q      <= 2'b00;
      last_dir   <= 2'b00;
      food_xq    <= '0;
      food_yq    <= '0;
      nxt_x      <= '0;
      nxt_y      <= '0;
      nxt_idx    <= '0;
      tail_idx   <= '0;
      grow_q     <= 1'b0;
    end else if (restart) begin
      state      <= S_INIT;
      step_ready <= 1'b0;
      step_done  <= 1'b0;
      ate        <= 1'b0;
      game_over  <= 1'b0;
      win        <= 1'b0;
      length     <= LEN_ONE;
      head_x     <= SX;
      head_y     <= SY;
      occ_map    <= OCC_START;
      head_ptr   <= '0;
      tail_ptr   <= '0;
      last_dir   <= 2'b00;
      grow_q     <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          state      <= S_IDLE;
          step_ready <= 1'b1;
        end
        S_IDLE: begin
          if (step_valid) begin
            step_ready <= 1'b0;
            dir_q      <= dir_eff;
            food_xq    <= food_x;
            food_yq    <= food_y;
            state      <= S_RD;
          end
        end
        S_RD: state <= S_CHK;
        S_CHK: begin
          nxt_x    <= cx;
          nxt_y    <= cy;
          nxt_idx  <= c_idx;
          tail_idx <= cell_idx(tail_x, tail_y);
          grow_q   <= c_grow;
          if (c_lose || c_win) begin
            game_over <= 1'b1;
            win       <= c_win;
            step_done <= 1'b1;
            ate       <= 1'b0;
            state     <= S_DONE;
          end else begin
            state <= S_WR;
          end
        end
        S_WR: begin
          head_ptr <= head_ptr + AW'(1);
          head_x   <= nxt_x;
          head_y   <= nxt_y;
          last_dir <= dir_q;
          if (grow_q) begin
            length <= length + (AW+1)'(1);
          end else begin
            occ_map[tail_idx] <= 1'b0;
            tail_ptr          <= tail_ptr + AW'(1);
          end
          // Later assignment wins, so stepping onto the old tail keeps the bit set.
          occ_map[nxt_idx] <= 1'b1;
          step_done        <= 1'b1;
          ate              <= grow_q;
          state            <= S_DONE;
        end
        S_DONE: begin
          step_done <= 1'b0;
          ate       <= 1'b0;
          if (game_over) begin
            state <= S_OVER;
          end else begin
            state      <= S_IDLE;
            step_ready <= 1'b1;
          end
        end
        S_OVER: state <= S_OVER;
        default: state <= S_INIT;
      endcase
    end
  end

endmodule
